// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the RegFile write port.
// RF_WARB_SCOREBOARD_EN adds the per-register pending bitmap.
interface regfile_write_arbiter_if #(
  parameter int N = 32,
  parameter int R = 5
);
  logic         req0_valid;
  logic         req0_ready;
  logic [R-1:0] req0_wa;
  logic [N-1:0] req0_wd;
  logic         req1_valid;
  logic         req1_ready;
  logic [R-1:0] req1_wa;
  logic [N-1:0] req1_wd;
  logic         rf_wen;
  logic [R-1:0] rf_wa;
  logic [N-1:0] rf_wd;
  logic         grant_id;
`ifdef RF_WARB_SCOREBOARD_EN
  logic [2**R-1:0] pending;
`endif

  modport master (
    output req0_valid, req0_wa, req0_wd, req1_valid, req1_wa, req1_wd,
    input  req0_ready, req1_ready, rf_wen, rf_wa, rf_wd, grant_id
`ifdef RF_WARB_SCOREBOARD_EN
    , input pending
`endif
  );

  modport slave (
    input  req0_valid, req0_wa, req0_wd, req1_valid, req1_wa, req1_wd,
    output req0_ready, req1_ready, rf_wen, rf_wa, rf_wd, grant_id
`ifdef RF_WARB_SCOREBOARD_EN
    , output pending
`endif
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the single RegFile write port, one FIFO per requester.
// Optional feature macro: RF_WARB_SCOREBOARD_EN (pending-write bitmap output).
module regfile_write_arbiter_fifo #(
  parameter int N     = 32,
  parameter int R     = 5,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enq,
  input  logic [R-1:0] enq_wa,
  input  logic [N-1:0] enq_wd,
  input  logic         deq,
  output logic         full,
  output logic         empty,
  output logic [R-1:0] head_wa,
  output logic [N-1:0] head_wd
`ifdef RF_WARB_SCOREBOARD_EN
  ,
  output logic [DEPTH-1:0]        ent_vld,
  output logic [DEPTH-1:0][R-1:0] ent_wa
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][R+N-1:0] mem_q, mem_d;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign head_wa = mem_q[rd_q[AW-1:0]][R+N-1:N];
  assign head_wd = mem_q[rd_q[AW-1:0]][N-1:0];

  always_comb begin
    wr_d  = wr_q + PW'(enq);
    rd_d  = rd_q + PW'(deq);
    mem_d = mem_q;
    if (enq) mem_d[wr_q[AW-1:0]] = {enq_wa, enq_wd};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

`ifdef RF_WARB_SCOREBOARD_EN
  logic [PW-1:0] cnt;
  logic [AW-1:0] off;
  assign cnt = wr_q - rd_q;
  always_comb begin
    ent_vld = '0;
    ent_wa  = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = AW'(i) - rd_q[AW-1:0];
      ent_vld[i] = ({1'b0, off} < cnt);
      ent_wa[i]  = mem_q[i][R+N-1:N];
    end
  end
`endif
endmodule

module regfile_write_arbiter #(
  parameter int N     = 32,
  parameter int R     = 5,
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]        in_valid, ready, enq, deq, fifo_full, fifo_empty;
  logic [NUM_REQ-1:0][R-1:0] in_wa, head_wa;
  logic [NUM_REQ-1:0][N-1:0] in_wd, head_wd;
`ifdef RF_WARB_SCOREBOARD_EN
  logic [NUM_REQ-1:0][DEPTH-1:0]        ent_vld;
  logic [NUM_REQ-1:0][DEPTH-1:0][R-1:0] ent_wa;
`endif

  assign in_valid = {bus.req1_valid, bus.req0_valid};
  assign in_wa    = {bus.req1_wa, bus.req0_wa};
  assign in_wd    = {bus.req1_wd, bus.req0_wd};
  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    // Writes to register 0 complete the handshake but are never queued.
    assign ready[g] = ~fifo_full[g] & ~reset;
    assign enq[g]   = in_valid[g] & ready[g] & (in_wa[g] != '0);

    regfile_write_arbiter_fifo #(.N(N), .R(R), .DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .enq     (enq[g]),
      .enq_wa  (in_wa[g]),
      .enq_wd  (in_wd[g]),
      .deq     (deq[g]),
      .full    (fifo_full[g]),
      .empty   (fifo_empty[g]),
      .head_wa (head_wa[g]),
      .head_wd (head_wd[g])
`ifdef RF_WARB_SCOREBOARD_EN
      ,
      .ent_vld (ent_vld[g]),
      .ent_wa  (ent_wa[g])
`endif
    );
  end

  logic         last_grant_q, last_grant_d;
  logic         rf_wen_q, rf_wen_d;
  logic [R-1:0] rf_wa_q, rf_wa_d;
  logic [N-1:0] rf_wd_q, rf_wd_d;
  logic         grant_id_q, grant_id_d;
  logic         issue, gnt;

  always_comb begin
    issue = ~&fifo_empty;
    if (!fifo_empty[0] && !fifo_empty[1]) gnt = ~last_grant_q;
    else                                  gnt = fifo_empty[0];
    deq          = '0;
    last_grant_d = last_grant_q;
    rf_wen_d     = issue;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;
    grant_id_d   = grant_id_q;
    if (issue) begin
      deq[gnt]     = 1'b1;
      last_grant_d = gnt;
      rf_wa_d      = head_wa[gnt];
      rf_wd_d      = head_wd[gnt];
      grant_id_d   = gnt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rf_wen_q     <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
      grant_id_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_wa    = rf_wa_q;
  assign bus.rf_wd    = rf_wd_q;
  assign bus.grant_id = grant_id_q;

`ifdef RF_WARB_SCOREBOARD_EN
  // A register stays pending until its write has occupied the rf_wen slot.
  logic [2**R-1:0] pend;
  always_comb begin
    pend = '0;
    for (int q = 0; q < NUM_REQ; q++)
      for (int e = 0; e < DEPTH; e++)
        if (ent_vld[q][e]) pend[ent_wa[q][e]] = 1'b1;
    if (rf_wen_q) pend[rf_wa_q] = 1'b1;
    pend[0] = 1'b0;
  end
  assign bus.pending = pend;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a queue-level model predicts each issued write; a negedge monitor checks the RegFile port.
module tb_regfile_write_arbiter;
  localparam int N = 32, R = 5, DEPTH = 2;

  typedef struct {
    logic         src;
    logic [R-1:0] wa;
    logic [N-1:0] wd;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.N(N), .R(R)) bus ();
  regfile_write_arbiter #(.N(N), .R(R), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0, errors = 0;
  wr_t q0[$], q1[$], exp_q[$];
  bit  m_last = 1'b1;
  logic [N-1:0] rf     [2**R];
  logic [N-1:0] mdl_rf [2**R];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each requester is a bounded queue; one head leaves per edge, round-robin on ties.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q0.delete(); q1.delete(); exp_q.delete();
      m_last = 1'b1;
    end else begin
      bit  acc0, acc1, pick;
      wr_t w;
      acc0 = bus.req0_valid && (q0.size() < DEPTH);
      acc1 = bus.req1_valid && (q1.size() < DEPTH);
      if (q0.size() > 0 || q1.size() > 0) begin
        if (q0.size() > 0 && q1.size() > 0) pick = !m_last;
        else                                pick = (q0.size() == 0);
        w = pick ? q1.pop_front() : q0.pop_front();
        m_last = pick;
        mdl_rf[w.wa] = w.wd;
        exp_q.push_back(w);
      end
      if (acc0 && bus.req0_wa != 0) q0.push_back('{1'b0, bus.req0_wa, bus.req0_wd});
      if (acc1 && bus.req1_wa != 0) q1.push_back('{1'b1, bus.req1_wa, bus.req1_wd});
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_wen", bus.rf_wen, 0);
      chk("rst_wa", bus.rf_wa, 0);
      chk("rst_wd", bus.rf_wd, 0);
      chk("rst_gid", bus.grant_id, 0);
      chk("rst_rdy", {bus.req1_ready, bus.req0_ready}, 0);
`ifdef RF_WARB_SCOREBOARD_EN
      chk("rst_pend", bus.pending, 0);
`endif
    end else begin
      chk("rdy0", bus.req0_ready, q0.size() < DEPTH);
      chk("rdy1", bus.req1_ready, q1.size() < DEPTH);
`ifdef RF_WARB_SCOREBOARD_EN
      begin
        logic [2**R-1:0] ep;
        ep = '0;
        foreach (q0[i]) ep[q0[i].wa] = 1'b1;
        foreach (q1[i]) ep[q1[i].wa] = 1'b1;
        if (exp_q.size() > 0) ep[exp_q[0].wa] = 1'b1;
        ep[0] = 1'b0;
        chk("pending", bus.pending, ep);
      end
`endif
      if (bus.rf_wen) begin
        if (exp_q.size() == 0) chk("spurious_wen", bus.rf_wen, 0);
        else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("gid", bus.grant_id, w.src);
          chk("wa", bus.rf_wa, w.wa);
          chk("wd", bus.rf_wd, w.wd);
        end
        rf[bus.rf_wa] = bus.rf_wd;
      end else if (exp_q.size() > 0) begin
        wr_t w;
        w = exp_q.pop_front();
        chk("missing_wen", bus.rf_wen, 1);
      end
    end
  end

  bit rdy0, rdy1;
  int k0, k1, acc1_cnt;

  task automatic nxt();
    @(negedge clock);
    #1;
  endtask

  // Offers a new payload only once the previous one has transferred; otherwise holds it.
  task automatic tick(input bit en0, input bit en1, input bit rnd);
    nxt();
    if (bus.req1_valid && rdy1) acc1_cnt++;
    if (!bus.req0_valid || rdy0) begin
      bus.req0_valid = en0;
      if (en0) begin
        bus.req0_wa = rnd ? R'($urandom_range(0, 7)) : R'(1 + k0 % 8);
        bus.req0_wd = $urandom;
        k0++;
      end
    end
    if (!bus.req1_valid || rdy1) begin
      bus.req1_valid = en1;
      if (en1) begin
        bus.req1_wa = rnd ? R'($urandom_range(0, 7)) : R'(9 + k1 % 8);
        bus.req1_wd = $urandom;
        k1++;
      end
    end
    rdy0 = bus.req0_ready;
    rdy1 = bus.req1_ready;
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    repeat (cyc) nxt();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2**R; i++) begin rf[i] = '0; mdl_rf[i] = '0; end
    bus.req0_valid = 0; bus.req0_wa = 0; bus.req0_wd = 0;
    bus.req1_valid = 0; bus.req1_wa = 0; bus.req1_wd = 0;
    do_reset(3);

    // Single path to register 5.
    nxt();
    bus.req0_valid = 1; bus.req0_wa = 5; bus.req0_wd = 32'hDEADBEEF;
    nxt();
    bus.req0_valid = 0;
    repeat (2) nxt();
    chk("reg5", rf[5], 32'hDEADBEEF);

    // Register 0 write is swallowed.
    bus.req0_valid = 1; bus.req0_wa = 0; bus.req0_wd = 32'hFFFFFFFF;
    chk("reg0_ready", bus.req0_ready, 1);
    nxt();
    bus.req0_valid = 0;
    repeat (3) nxt();
    chk("reg0", rf[0], 0);

    // Contention from a fresh reset: grants alternate starting with requester 0.
    do_reset(2);
    rdy0 = bus.req0_ready; rdy1 = bus.req1_ready;
    repeat (12) tick(1, 1, 0);
    repeat (6) tick(0, 0, 0);

    // Backpressure: requester 1 offers exactly 3 writes while requester 0 saturates.
    begin
      int start_k1, budget;
      start_k1 = k1;
      acc1_cnt = 0;
      budget   = 0;
      while (acc1_cnt < 3 && budget < 50) begin
        tick(1, (k1 - start_k1) < 3, 0);
        budget++;
      end
      chk("bp_accepts", acc1_cnt, 3);
    end
    repeat (8) tick(0, 0, 0);

    // Mid-stream reset discards queued writes.
    repeat (3) tick(1, 1, 0);
    reset = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    nxt();
    chk("midrst_wen", bus.rf_wen, 0);
    nxt();
    reset = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0;
    nxt();
    chk("post_rdy", {bus.req1_ready, bus.req0_ready}, 2'b11);
    repeat (4) nxt();

    // Randomized traffic with colliding addresses and register 0.
    repeat (400) tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1);
    repeat (10) tick(0, 0, 0);

    chk("drained", q0.size() + q1.size() + exp_q.size(), 0);
    for (int i = 0; i < 2**R; i++) chk("rf_final", rf[i], mdl_rf[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
